// File: rtl/and_mask_stage.sv
// and_mask_stage: serialises a received M-bit word into bytes (LSB first),
// masks each byte and hands it to a UART transmitter with a start/done
// handshake.
// Optional build macro AND_MASK_LFSR_EN: when defined, the mask comes from
// an 8-bit Fibonacci LFSR that persists across words. When undefined, the
// mask is 8'hFF, so bytes pass through unchanged, and no LFSR is built.
module and_mask_stage #(
  parameter int         M    = 8,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic         clk,
  input  logic         RstFSM,
  input  logic         AndEnable,
  input  logic [M-1:0] RxWord,
  input  logic         TxDone,
  output logic [7:0]   TxData,
  output logic         TxStart,
  output logic         AndDone,
  output logic         Busy
);

  localparam int NB = M / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_MASK    = 3'd2,
    S_WAIT_TX = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  w_idx_nxt;
  logic [M-1:0]   r_word;
  logic [M-1:0]   w_word_nxt;
  logic [7:0]     r_tx_data;
  logic [7:0]     w_tx_data_nxt;
  logic           r_tx_start;
  logic           w_tx_start_nxt;
  logic           r_and_done;
  logic           w_and_done_nxt;
  logic           r_busy;
  logic [7:0]     w_byte;
  logic [7:0]     w_mask;

`ifdef AND_MASK_LFSR_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_step;

  // One Fibonacci step: shift left, feedback taps 7,5,4,3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // The LFSR advances only when a byte is actually launched (MASK, not aborting).
  assign w_lfsr_step = (r_state == S_MASK) && AndEnable;
  assign w_mask      = r_lfsr;

  // LFSR register: seeded on reset, self-heals from the all-zero lock-up state.
  always_ff @(posedge clk or negedge RstFSM) begin
    if (!RstFSM) begin
      r_lfsr <= SEED;
    end else if (r_lfsr == 8'h00) begin
      r_lfsr <= SEED;
    end else if (w_lfsr_step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end
`else
  assign w_mask = 8'hFF;
`endif

  // Select the byte of the captured word addressed by the byte index.
  always_comb begin
    w_byte = 8'h00;
    for (int b = 0; b < NB; b++) begin
      w_byte = (r_idx == IW'(b)) ? r_word[8*b +: 8] : w_byte;
    end
  end

  // Next-state and next-output logic; AndEnable low aborts any active transfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_word_nxt     = r_word;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_and_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (AndEnable) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!AndEnable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_word_nxt  = RxWord;
          w_idx_nxt   = '0;
          w_state_nxt = S_MASK;
        end
      end
      S_MASK: begin
        if (!AndEnable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tx_data_nxt  = w_byte & w_mask;
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (!AndEnable) begin
          w_state_nxt = S_IDLE;
        end else if (TxDone) begin
          if (r_idx == LAST_IDX) begin
            w_and_done_nxt = 1'b1;
            w_state_nxt    = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_MASK;
          end
        end else begin
          w_state_nxt = S_WAIT_TX;
        end
      end
      S_DONE: begin
        if (!AndEnable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_and_done_nxt = 1'b1;
          w_state_nxt    = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge RstFSM) begin
    if (!RstFSM) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs; reset clears any pending pulse at once.
  always_ff @(posedge clk or negedge RstFSM) begin
    if (!RstFSM) begin
      r_idx      <= '0;
      r_word     <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_and_done <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_word     <= w_word_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_and_done <= w_and_done_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign TxData  = r_tx_data;
  assign TxStart = r_tx_start;
  assign AndDone = r_and_done;
  assign Busy    = r_busy;

endmodule

// File: tb/tb_and_mask_stage.sv
// Bench for and_mask_stage (M=16). Expected bytes go into a scoreboard queue
// when a word is driven and are compared whenever TxStart is seen.
module tb_and_mask_stage;

  logic        clk;
  logic        RstFSM;
  logic        AndEnable;
  logic [15:0] RxWord;
  logic        TxDone;
  logic [7:0]  TxData;
  logic        TxStart;
  logic        AndDone;
  logic        Busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  and_mask_stage #(.M(16), .SEED(8'hA5)) dut (
    .clk(clk), .RstFSM(RstFSM), .AndEnable(AndEnable), .RxWord(RxWord),
    .TxDone(TxDone), .TxData(TxData), .TxStart(TxStart), .AndDone(AndDone),
    .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every TxStart pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (RstFSM === 1'b1 && TxStart === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_txstart: got TxData %0h with empty scoreboard at %0t", TxData, $time);
      end else begin
        chk("txdata", 16'(TxData), 16'(exp_q.pop_front()));
      end
    end
  end

`ifdef AND_MASK_LFSR_EN
  logic [7:0] m_lfsr = 8'hA5;
  task automatic model_mask(output logic [7:0] m);
    m = m_lfsr;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask
  task automatic model_reset();
    m_lfsr = 8'hA5;
  endtask
`else
  task automatic model_mask(output logic [7:0] m);
    m = 8'hFF;
  endtask
  task automatic model_reset();
  endtask
`endif

  // Full two-byte word with TxDone 3 cycles after each TxStart.
  task automatic run_word(input logic [15:0] w, input logic [7:0] e0,
                          input logic [7:0] e1, input bit spur);
    logic [7:0] ex;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    @(posedge clk); #1;
    RxWord = w;
    AndEnable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("lat_early", 16'(TxStart), 16'h0);
    chk("busy_run", 16'(Busy), 16'h1);
    @(posedge clk); #1;
    chk("lat_first", 16'(TxStart), 16'h1);
    for (int b = 0; b < 2; b++) begin
      ex = (b == 0) ? e0 : e1;
      @(posedge clk); #1;
      chk("start_pulse", 16'(TxStart), 16'h0);
      chk("hold_txdata", 16'(TxData), 16'(ex));
      @(posedge clk); #1;
      TxDone = 1'b1;
      @(posedge clk); #1;
      TxDone = 1'b0;
      if (b == 0) begin
        chk("lat_next_early", 16'(TxStart), 16'h0);
        chk("done_early", 16'(AndDone), 16'h0);
        @(posedge clk); #1;
        chk("lat_next", 16'(TxStart), 16'h1);
      end else begin
        chk("and_done", 16'(AndDone), 16'h1);
        chk("busy_done", 16'(Busy), 16'h1);
      end
    end
    if (spur) begin
      TxDone = 1'b1;
      @(posedge clk); #1;
      TxDone = 1'b0;
      chk("spur_done_anddone", 16'(AndDone), 16'h1);
      chk("spur_done_busy", 16'(Busy), 16'h1);
      @(posedge clk); #1;
      chk("spur_done_nostart", 16'(TxStart), 16'h0);
    end
    AndEnable = 1'b0;
    @(posedge clk); #1;
    chk("done_clear", 16'(AndDone), 16'h0);
    chk("idle_busy", 16'(Busy), 16'h0);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] m;
`ifdef AND_MASK_LFSR_EN
    tbl[0] = '{16'hFFFF, 8'hA5, 8'h4A};
    tbl[1] = '{16'h0F0F, 8'h05, 8'h0A};
    tbl[2] = '{16'h3CA7, 8'h04, 8'h28};
    tbl[3] = '{16'h00FF, 8'h53, 8'h00};
    tbl[4] = '{16'h8001, 8'h00, 8'h80};
`else
    tbl[0] = '{16'hFFFF, 8'hFF, 8'hFF};
    tbl[1] = '{16'h0F0F, 8'h0F, 8'h0F};
    tbl[2] = '{16'h3CA7, 8'hA7, 8'h3C};
    tbl[3] = '{16'h00FF, 8'hFF, 8'h00};
    tbl[4] = '{16'h8001, 8'h01, 8'h80};
`endif
    RstFSM = 1'b0;
    AndEnable = 1'b0;
    TxDone = 1'b0;
    RxWord = 16'h0000;
    #1;
    chk("rst_txdata", 16'(TxData), 16'h0);
    chk("rst_txstart", 16'(TxStart), 16'h0);
    chk("rst_anddone", 16'(AndDone), 16'h0);
    chk("rst_busy", 16'(Busy), 16'h0);
    repeat (2) @(posedge clk);
    #1 RstFSM = 1'b1;

    // Spurious TxDone while idle.
    @(posedge clk); #1;
    TxDone = 1'b1;
    @(posedge clk); #1;
    TxDone = 1'b0;
    chk("spur_idle_busy", 16'(Busy), 16'h0);
    @(posedge clk); #1;
    chk("spur_idle_nostart", 16'(TxStart), 16'h0);

    for (int i = 0; i < 5; i++) begin
      run_word(tbl[i].word, tbl[i].e0, tbl[i].e1, (i == 1));
      model_mask(m);
      model_mask(m);
    end

    // Abort: drop AndEnable in WAIT_TX before TxDone.
    model_mask(m);
    exp_q.push_back(8'h34 & m);
    @(posedge clk); #1;
    RxWord = 16'h1234;
    AndEnable = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_start", 16'(TxStart), 16'h1);
    @(posedge clk); #1;
    AndEnable = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 16'(Busy), 16'h0);
    chk("abort_anddone", 16'(AndDone), 16'h0);
    TxDone = 1'b1;
    @(posedge clk); #1;
    TxDone = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_still_idle", 16'(Busy), 16'h0);
    chk("abort_no_done", 16'(AndDone), 16'h0);

    // Next word continues the mask sequence after the abort.
    begin
      logic [7:0] m0;
      logic [7:0] m1;
      model_mask(m0);
      model_mask(m1);
      run_word(16'h5AC3, 8'hC3 & m0, 8'h5A & m1, 1'b0);
    end

    // Reset asserted mid-WAIT_TX.
    model_mask(m);
    exp_q.push_back(8'hCD & m);
    @(posedge clk); #1;
    RxWord = 16'hABCD;
    AndEnable = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_start", 16'(TxStart), 16'h1);
    @(posedge clk); #1;
    RstFSM = 1'b0;
    #1;
    chk("rst_mid_txdata", 16'(TxData), 16'h0);
    chk("rst_mid_txstart", 16'(TxStart), 16'h0);
    chk("rst_mid_anddone", 16'(AndDone), 16'h0);
    chk("rst_mid_busy", 16'(Busy), 16'h0);
    AndEnable = 1'b0;
    @(posedge clk); #1;
    RstFSM = 1'b1;
    model_reset();
`ifdef AND_MASK_LFSR_EN
    run_word(16'h00FF, 8'hA5, 8'h00, 1'b0);
`else
    run_word(16'h00FF, 8'hFF, 8'h00, 1'b0);
`endif
    model_mask(m);
    model_mask(m);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 16'(exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
